// File: rtl/cdc_pkg.sv
// cdc_pkg: shared types and default constants for the cdc_xfer_arb slice
package cdc_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, REQ_HI, REQ_LO} state_t;
  typedef enum logic {RR_0, RR_1} rr_t;
  localparam int DEF_BUS_WIDTH  = 8;
  localparam int DEF_NUM_STAGES = 2;
  localparam int DEF_TIMEOUT    = 64;
endpackage

// File: rtl/cdc_xfer_arb_ack_sync.sv
// ack_sync: NUM_STAGES-flop single-bit synchronizer, cleared to 0 by reset
// Ports: CLK destination clock, RST async active-low reset, i_d async input, o_q synchronized output
module ack_sync #(
  parameter int NUM_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_d,
  output logic o_q
);
  logic [NUM_STAGES-1:0] r_sync;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) r_sync <= '0;
    else r_sync <= (r_sync << 1) | NUM_STAGES'(i_d);
  assign o_q = r_sync[NUM_STAGES-1];
endmodule

// File: rtl/cdc_xfer_arb.sv
// cdc_xfer_arb: round-robin arbiter for two requesters feeding a 4-phase bus handshake into another clock domain
// Ports: CLK/RST (async active-low) source clock and reset; REQ0/REQ1 + DATA0/DATA1 level requests with payloads;
//        GNT0/GNT1 acceptance pulses; BUS_OUT/BUS_EN held word and enable towards the destination synchronizer;
//        ACK_ASYNC destination acknowledge; BUSY transfer in progress; DONE completion pulse; ERR timeout pulse.
// Optional: define CDC_ARB_TIMEOUT_EN to abort a stalled handshake phase after TIMEOUT cycles (ERR pulse, no DONE).
module cdc_xfer_arb
  import cdc_pkg::*;
#(
  parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ0,
  input  logic                 REQ1,
  input  logic [BUS_WIDTH-1:0] DATA0,
  input  logic [BUS_WIDTH-1:0] DATA1,
  output logic                 GNT0,
  output logic                 GNT1,
  output logic [BUS_WIDTH-1:0] BUS_OUT,
  output logic                 BUS_EN,
  input  logic                 ACK_ASYNC,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERR
);
  state_t r_state, w_next;
  rr_t r_last;
  logic [BUS_WIDTH-1:0] r_bus_out;
  logic r_bus_en, r_gnt0, r_gnt1, r_done;
  logic w_ack_s, w_to, w_accept, w_pick1, w_gnt0_nx, w_gnt1_nx, w_done_nx, w_en_nx;

  ack_sync #(.NUM_STAGES(NUM_STAGES)) u_ack_sync (
    .CLK(CLK),
    .RST(RST),
    .i_d(ACK_ASYNC),
    .o_q(w_ack_s)
  );

`ifdef CDC_ARB_TIMEOUT_EN
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] r_cnt;
  logic r_err, w_err_nx;
  assign w_to = r_cnt == CW'(TIMEOUT - 1);
  // Abort only when the awaited ack level has not arrived in this same cycle.
  assign w_err_nx = w_to && ((r_state == REQ_HI && !w_ack_s) || (r_state == REQ_LO && w_ack_s));
  // Counts cycles spent in a wait phase; restarts on every state change.
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= (w_next == r_state && (r_state == REQ_HI || r_state == REQ_LO)) ? r_cnt + 1'b1 : '0;
      r_err <= w_err_nx;
    end
  assign ERR = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = TIMEOUT[0];
  assign w_to = 1'b0;
  assign ERR = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      r_state   <= IDLE;
      r_last    <= RR_1;
      r_bus_out <= '0;
      r_bus_en  <= 1'b0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_bus_en <= w_en_nx;
      r_gnt0   <= w_gnt0_nx;
      r_gnt1   <= w_gnt1_nx;
      r_done   <= w_done_nx;
      if (w_accept) begin
        r_bus_out <= w_pick1 ? DATA1 : DATA0;
        r_last    <= w_pick1 ? RR_1 : RR_0;
      end
    end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? SETUP : IDLE;
      SETUP:   w_next = REQ_HI;
      REQ_HI:  w_next = w_ack_s ? REQ_LO : (w_to ? IDLE : REQ_HI);
      REQ_LO:  w_next = (!w_ack_s || w_to) ? IDLE : REQ_LO;
      default: w_next = IDLE;
    endcase
  end

  // Requester 1 wins when alone, or when both ask and requester 0 was served last.
  always_comb begin
    w_accept  = r_state == IDLE && !w_ack_s && (REQ0 || REQ1);
    w_pick1   = REQ1 && (!REQ0 || r_last == RR_0);
    w_gnt0_nx = w_accept && !w_pick1;
    w_gnt1_nx = w_accept && w_pick1;
    w_done_nx = r_state == REQ_LO && !w_ack_s;
    w_en_nx   = w_next == REQ_HI;
  end

  assign GNT0    = r_gnt0;
  assign GNT1    = r_gnt1;
  assign BUS_OUT = r_bus_out;
  assign BUS_EN  = r_bus_en;
  assign DONE    = r_done;
  assign BUSY    = r_state != IDLE;
endmodule

// File: tb/tb_cdc_xfer_arb.sv
// tb_cdc_xfer_arb: randomized and directed self-checking bench for cdc_xfer_arb against a transaction-level model
module tb_cdc_xfer_arb;
  localparam int BW = 8;
  localparam int NS = 2;
`ifdef CDC_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 64;
`endif
  logic CLK = 0, RST = 0, REQ0 = 0, REQ1 = 0, ACK_ASYNC = 0;
  logic [BW-1:0] DATA0 = 0, DATA1 = 0, BUS_OUT;
  logic GNT0, GNT1, BUS_EN, BUSY, DONE, ERR;
  int tests = 0, fails = 0;

  cdc_xfer_arb #(.BUS_WIDTH(BW), .NUM_STAGES(NS), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1), .DATA0(DATA0), .DATA1(DATA1),
    .GNT0(GNT0), .GNT1(GNT1), .BUS_OUT(BUS_OUT), .BUS_EN(BUS_EN), .ACK_ASYNC(ACK_ASYNC),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Destination side: echoes BUS_EN back as ACK after dly samples, unless held stuck.
  int dly = 1;
  bit stuck = 0, stuck_val = 0;
  bit en_hist[$];
  always @(negedge CLK) begin
    en_hist.push_back(BUS_EN);
    if (en_hist.size() > 8) void'(en_hist.pop_front());
    #1;
    ACK_ASYNC = stuck ? stuck_val : (en_hist.size() >= dly ? en_hist[en_hist.size() - dly] : 1'b0);
  end

  // Reference model: one transfer in flight at most; m_phase -1 none, 0 data setup,
  // 1 waiting for ack high, 2 waiting for ack low. The ack it reacts to is ACK_ASYNC seen NS edges earlier.
  int m_phase, m_wait, m_w;
  bit m_last, m_g0, m_g1, m_done, m_err, m_a;
  logic [BW-1:0] m_out;
  bit ack_hist[$];
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_phase = -1; m_wait = 0; m_last = 1; m_out = '0;
      m_g0 = 0; m_g1 = 0; m_done = 0; m_err = 0;
      ack_hist.delete();
    end else begin
      m_a = ack_hist.size() >= NS ? ack_hist[ack_hist.size() - NS] : 1'b0;
      ack_hist.push_back(ACK_ASYNC);
      if (ack_hist.size() > 16) void'(ack_hist.pop_front());
      m_g0 = 0; m_g1 = 0; m_done = 0; m_err = 0;
      if (m_phase < 0) begin
        if (!m_a && (REQ0 || REQ1)) begin
          m_w = (REQ0 && REQ1) ? (m_last ? 0 : 1) : (REQ1 ? 1 : 0);
          m_last = (m_w == 1);
          m_out = m_w == 1 ? DATA1 : DATA0;
          m_g0 = (m_w == 0); m_g1 = (m_w == 1);
          m_phase = 0;
        end
      end else if (m_phase == 0) begin
        m_phase = 1; m_wait = 0;
      end else if (m_a == (m_phase == 1)) begin
        if (m_phase == 1) begin m_phase = 2; m_wait = 0; end
        else begin m_phase = -1; m_done = 1; end
      end
`ifdef CDC_ARB_TIMEOUT_EN
      else if (m_wait == TO - 1) begin m_phase = -1; m_err = 1; end
`endif
      else m_wait++;
    end
  end

  // Per-cycle comparison plus an event log used by the directed checks.
  int cyc = 0, n_done = 0, n_err = 0, t_gnt = 0, t_done = 0, t_err = 0;
  bit en_seen = 0;
  int g_log[$];
  logic [BW-1:0] d_log[$];
  always @(negedge CLK) begin
    tests++;
    if ({GNT0, GNT1, DONE, ERR, BUSY, BUS_EN, BUS_OUT} !== {m_g0, m_g1, m_done, m_err, m_phase >= 0, m_phase == 1, m_out}) begin
      fails++;
      $display("FAIL cycle %0d: dut gnt=%b%b done=%b err=%b busy=%b en=%b bus=%h, model gnt=%b%b done=%b err=%b busy=%b en=%b bus=%h",
               cyc, GNT0, GNT1, DONE, ERR, BUSY, BUS_EN, BUS_OUT,
               m_g0, m_g1, m_done, m_err, m_phase >= 0, m_phase == 1, m_out);
    end
    if (GNT0 || GNT1) begin g_log.push_back(GNT1 ? 1 : 0); d_log.push_back(BUS_OUT); t_gnt = cyc; end
    if (DONE) begin n_done++; t_done = cyc; end
    if (ERR) begin n_err++; t_err = cyc; end
    if (BUS_EN) en_seen = 1;
    cyc++;
  end

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    #2;
  endtask

  task automatic clear_log();
    g_log.delete(); d_log.delete(); n_done = 0; n_err = 0; en_seen = 0;
  endtask

  task automatic do_reset();
    step();
    RST = 0; REQ0 = 0; REQ1 = 0;
    repeat (3) step();
    RST = 1;
    clear_log();
  endtask

  task automatic wait_gnt(input int limit);
    for (int i = 0; i < limit && g_log.size() == 0; i++) step();
  endtask

  task automatic wait_done(input int n, input int limit);
    for (int i = 0; i < limit && n_done < n; i++) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    chk("reset_busy", BUSY, 0);
    chk("reset_bus_out", BUS_OUT, 0);
    // Single transfer, ack looped back after 3 samples: GNT to DONE = 1 + 2*(2+3).
    dly = 3;
    do_reset();
    step();
    REQ0 = 1; DATA0 = 8'hA5;
    wait_gnt(20);
    REQ0 = 0;
    wait_done(1, 60);
    chk("single_gnt_count", g_log.size(), 1);
    chk("single_gnt_who", g_log.size() > 0 ? g_log[0] : -1, 0);
    chk("single_bus_out", d_log.size() > 0 ? int'(d_log[0]) : -1, 'hA5);
    chk("single_en_seen", en_seen, 1);
    chk("single_done", n_done, 1);
    chk("single_latency", t_done - t_gnt, 11);
    chk("single_busy_after", BUSY, 0);
    // Both requesters held high: strict alternation starting with requester 0.
    dly = 2;
    do_reset();
    REQ0 = 1; REQ1 = 1; DATA0 = 8'h11; DATA1 = 8'h22;
    wait_done(4, 200);
    REQ0 = 0; REQ1 = 0;
    chk("rr_done", n_done, 4);
    chk("rr_gnts", g_log.size(), 4);
    for (int i = 0; i < 4 && i < g_log.size(); i++) begin
      chk($sformatf("rr_who%0d", i), g_log[i], i % 2);
      chk($sformatf("rr_bus%0d", i), int'(d_log[i]), (i % 2) ? 'h22 : 'h11);
    end
    // Ack stuck high from reset blocks acceptance until it falls.
    stuck = 1; stuck_val = 1;
    do_reset();
    repeat (4) step();
    REQ1 = 1; DATA1 = 8'h7E;
    repeat (15) step();
    chk("stuck_no_gnt", g_log.size(), 0);
    chk("stuck_busy", BUSY, 0);
    stuck = 0;
    wait_gnt(20);
    REQ1 = 0;
    chk("stuck_gnt_who", g_log.size() > 0 ? g_log[0] : -1, 1);
    wait_done(1, 60);
    chk("stuck_done", n_done, 1);
    // Payload changes after capture must not reach BUS_OUT.
    dly = 4;
    do_reset();
    REQ0 = 1; DATA0 = 8'h3C;
    wait_gnt(20);
    REQ0 = 0;
    for (int i = 0; i < 20 && !BUS_EN; i++) step();
    repeat (3) begin DATA0 = 8'($urandom); step(); end
    chk("hold_en_high", BUS_EN, 1);
    chk("hold_bus_out", BUS_OUT, 'h3C);
    wait_done(1, 60);
    chk("hold_bus_out_done", BUS_OUT, 'h3C);
    // Reset in the middle of REQ_HI discards the transfer.
    do_reset();
    REQ0 = 1; DATA0 = 8'h3C;
    wait_gnt(20);
    REQ0 = 0;
    for (int i = 0; i < 20 && !BUS_EN; i++) step();
    chk("rst_pre_bus", BUS_OUT, 'h3C);
    RST = 0;
    #1;
    chk("rst_bus_en", BUS_EN, 0);
    chk("rst_bus_out", BUS_OUT, 0);
    chk("rst_busy", BUSY, 0);
    repeat (4) step();
    RST = 1;
    chk("rst_no_done", n_done + n_err, 0);
    clear_log();
    REQ0 = 1; DATA0 = 8'h5A;
    wait_gnt(40);
    REQ0 = 0;
    wait_done(1, 80);
    chk("rst_after_done", n_done, 1);
    chk("rst_after_bus", d_log.size() > 0 ? int'(d_log[0]) : -1, 'h5A);
`ifdef CDC_ARB_TIMEOUT_EN
    // Ack never rises: ERR 16 cycles after REQ_HI entry (17 after GNT), no DONE.
    stuck = 1; stuck_val = 0;
    do_reset();
    REQ0 = 1; DATA0 = 8'h99;
    wait_gnt(20);
    REQ0 = 0;
    for (int i = 0; i < 60 && n_err == 0; i++) step();
    chk("to_err", n_err, 1);
    chk("to_latency", t_err - t_gnt, 17);
    chk("to_bus_en", BUS_EN, 0);
    chk("to_no_done", n_done, 0);
    stuck = 0;
`endif
    // Randomized traffic with varying destination delay.
    for (int s = 0; s < 4; s++) begin
      dly = $urandom_range(4, 1);
      do_reset();
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(3, 0) == 0) REQ0 = ~REQ0;
        if ($urandom_range(3, 0) == 0) REQ1 = ~REQ1;
        if ($urandom_range(2, 0) == 0) DATA0 = 8'($urandom);
        if ($urandom_range(2, 0) == 0) DATA1 = 8'($urandom);
`ifdef CDC_ARB_TIMEOUT_EN
        if ($urandom_range(199, 0) == 0) begin stuck = ~stuck; stuck_val = 1'($urandom); end
`endif
        step();
      end
      stuck = 0;
    end
    REQ0 = 0; REQ1 = 0;
    repeat (40) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
